// File: rtl/i2c_vector_target.sv
// I2C target that serves a parallel array of 16-bit words, high byte first.
// A write of one byte loads the word pointer; reads stream words with wrap-around.
module i2c_vector_target #(
  parameter logic [6:0]  DEV_ADDR = 7'h48,
  parameter int unsigned WORDS    = 26
) (
  input  logic                   clk,
  input  logic                   rst,
  inout  wire                    scl,
  inout  wire                    sda,
  input  logic [WORDS-1:0][15:0] vec,
  output logic [4:0]             ptr,
  output logic                   busy,
  output logic                   word_sent
);

  localparam int unsigned PTR_W = 5;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, TX, TX_ACK, WAIT_STOP
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         scl_sh_q, scl_sh_d;
  logic [2:0]         sda_sh_q, sda_sh_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]         rx_q, rx_d;
  logic [15:0]        tx_sr_q, tx_sr_d;
  logic               hi_byte_q, hi_byte_d;
  logic               rw_q, rw_d;
  logic               sda_oe_q, sda_oe_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               busy_q, busy_d;
  logic               word_sent_q, word_sent_d;

  logic               scl_s, scl_p, sda_s, sda_p;
  logic               scl_rise, scl_fall, start_det, stop_det;
  logic [PTR_W-1:0]   ptr_inc;
  logic [15:0]        word_vec;

  // Bit [1] of each shift chain is the synchronized value, bit [2] its previous sample.
  assign scl_s     = scl_sh_q[1];
  assign scl_p     = scl_sh_q[2];
  assign sda_s     = sda_sh_q[1];
  assign sda_p     = sda_sh_q[2];
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & sda_p & ~sda_s;
  assign stop_det  = scl_s & ~sda_p & sda_s;
  assign ptr_inc   = (ptr_q == PTR_W'(WORDS - 1)) ? '0 : ptr_q + PTR_W'(1);
  assign word_vec  = vec[ptr_q];

  assign sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign ptr       = ptr_q;
  assign busy      = busy_q;
  assign word_sent = word_sent_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      scl_sh_q    <= '1;
      sda_sh_q    <= '1;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_sr_q     <= '0;
      hi_byte_q   <= 1'b0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      ptr_q       <= '0;
      busy_q      <= 1'b0;
      word_sent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      scl_sh_q    <= scl_sh_d;
      sda_sh_q    <= sda_sh_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_sr_q     <= tx_sr_d;
      hi_byte_q   <= hi_byte_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      word_sent_q <= word_sent_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    scl_sh_d    = {scl_sh_q[1:0], scl};
    sda_sh_d    = {sda_sh_q[1:0], sda};
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_sr_d     = tx_sr_q;
    hi_byte_d   = hi_byte_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    ptr_d       = ptr_q;
    busy_d      = busy_q;
    word_sent_d = 1'b0;

    // STOP has priority over START when both appear in the same cycle.
    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
        end
        ADDR: begin
          if (scl_rise) begin
            rx_d      = {rx_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else if (scl_fall && bit_cnt_q == CNT_W'(8)) begin
            bit_cnt_d = '0;
            if (rx_q[7:1] == DEV_ADDR) begin
              state_d  = ADDR_ACK;
              rw_d     = rx_q[0];
              busy_d   = 1'b1;
              sda_oe_d = 1'b1;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (rw_q) begin
              state_d   = TX;
              hi_byte_d = 1'b1;
              tx_sr_d   = {word_vec[14:0], 1'b0};
              sda_oe_d  = ~word_vec[15];
            end else begin
              state_d  = PTR;
              sda_oe_d = 1'b0;
            end
          end
        end
        PTR: begin
          if (scl_rise) begin
            rx_d      = {rx_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else if (scl_fall && bit_cnt_q == CNT_W'(8)) begin
            bit_cnt_d = '0;
            if (32'(rx_q) < WORDS) begin
              state_d  = PTR_ACK;
              ptr_d    = PTR_W'(rx_q);
              sda_oe_d = 1'b1;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        // Any further write byte finds sda released, i.e. it is NACKed.
        PTR_ACK: begin
          if (scl_fall) begin
            state_d  = WAIT_STOP;
            sda_oe_d = 1'b0;
          end
        end
        TX: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else if (scl_fall) begin
            if (bit_cnt_q == CNT_W'(8)) begin
              state_d  = TX_ACK;
              sda_oe_d = 1'b0;
            end else begin
              sda_oe_d = ~tx_sr_q[15];
              tx_sr_d  = {tx_sr_q[14:0], 1'b0};
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (!hi_byte_q) begin
              word_sent_d = 1'b1;
              ptr_d       = ptr_inc;
            end
            if (sda_s) begin
              state_d = WAIT_STOP;
            end
          end else if (scl_fall) begin
            bit_cnt_d = '0;
            state_d   = TX;
            if (hi_byte_q) begin
              hi_byte_d = 1'b0;
              sda_oe_d  = ~tx_sr_q[15];
              tx_sr_d   = {tx_sr_q[14:0], 1'b0};
            end else begin
              hi_byte_d = 1'b1;
              tx_sr_d   = {word_vec[14:0], 1'b0};
              sda_oe_d  = ~word_vec[15];
            end
          end
        end
        WAIT_STOP: begin
        end
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

endmodule
